// File: rtl/cpu_difference_ctrl.sv
// Avalon-MM controller that walks pixel pairs and accumulates a saturating sum of differences.
// Optional build macro DIFF_SQUARE_EN switches the accumulated term to the squared difference.
module cpu_difference_ctrl #(
    parameter int PIX_W = 8,
    parameter int IDX_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    output logic             pix_req,
    output logic [IDX_W-1:0] pix_index,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_a,
    input  logic [PIX_W-1:0] pix_b
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [31:0]      diff_q, diff_d;
    logic [IDX_W-1:0] length_q, length_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic             done_q, done_d;
    logic             irq_en_q, irq_en_d;
    logic [31:0]      readdata_q, readdata_d;

    logic             busy;
    logic             ctrl_wr;
    logic [PIX_W-1:0] abs_diff;
    logic [31:0]      term;
    logic [32:0]      sum;
    logic [31:0]      acc_next;
    logic             square_flag;

    assign busy     = (state_q == S_FETCH);
    assign ctrl_wr  = write && (address == 2'd2);
    assign abs_diff = (pix_a >= pix_b) ? (pix_a - pix_b) : (pix_b - pix_a);

`ifdef DIFF_SQUARE_EN
    logic [2*PIX_W-1:0] square;
    assign square      = {{PIX_W{1'b0}}, abs_diff} * {{PIX_W{1'b0}}, abs_diff};
    assign term        = 32'(square);
    assign square_flag = 1'b1;
`else
    assign term        = 32'(abs_diff);
    assign square_flag = 1'b0;
`endif

    // One extra carry bit tells us the add would wrap, so we clamp instead.
    assign sum      = {1'b0, diff_q} + {1'b0, term};
    assign acc_next = sum[32] ? 32'hFFFF_FFFF : sum[31:0];

    generate
        if (IDX_W < 32) begin : g_unused_wdata
            logic unused_wdata;
            assign unused_wdata = ^writedata[31:IDX_W];
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        diff_d   = diff_q;
        length_d = length_q;
        index_d  = index_q;
        done_d   = done_q;
        irq_en_d = irq_en_q;

        if (ctrl_wr) begin
            irq_en_d = writedata[2];
            if (writedata[1]) begin
                done_d = 1'b0;
            end
        end
        if (write && (address == 2'd3) && !busy) begin
            length_d = writedata[IDX_W-1:0];
        end

        case (state_q)
            S_FETCH: begin
                if (pix_valid) begin
                    diff_d = acc_next;
                    if (index_q == length_q - 1'b1) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        index_d = index_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                // START overrides a CLR_DONE written in the same word.
                if (ctrl_wr && writedata[0]) begin
                    diff_d = 32'd0;
                    if (length_q != '0) begin
                        index_d = '0;
                        done_d  = 1'b0;
                        state_d = S_FETCH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
        endcase
    end

    always_comb begin
        readdata_d = 32'd0;
        case (address)
            2'd0:    readdata_d = diff_q;
            2'd1:    readdata_d = {28'd0, square_flag, irq_en_q, done_q, busy};
            2'd3:    readdata_d = 32'(length_q);
            default: readdata_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            diff_q     <= 32'd0;
            length_q   <= '0;
            index_q    <= '0;
            done_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            readdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            diff_q     <= diff_d;
            length_q   <= length_d;
            index_q    <= index_d;
            done_q     <= done_d;
            irq_en_q   <= irq_en_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata  = readdata_q;
    assign irq       = done_q & irq_en_q;
    assign pix_req   = busy;
    assign pix_index = index_q;
endmodule
